// File: rtl/tl_ul_channel_buffer_if.sv
// One TL-UL channel (A or D): valid/ready handshake plus an opaque payload of W bits.
// The master modport drives the beat; the slave modport accepts it.
interface tl_ul_channel_buffer_if #(
    parameter int unsigned W = 1
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] bits;

    modport master (output valid, output bits, input  ready);
    modport slave  (input  valid, input  bits, output ready);
endinterface

// File: rtl/tl_ul_channel_buffer.sv
// TL-UL buffer: independent A (downstream) and D (upstream) FIFOs, depth 0 = pure wires.
// Optional macro TL_BUFFER_PIPE_EN lets a full FIFO accept a beat while its head dequeues.
module tl_ul_channel_buffer #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned SIZE_W   = 2,
    parameter int unsigned SOURCE_W = 2,
    parameter int unsigned A_DEPTH  = 2,
    parameter int unsigned D_DEPTH  = 2,
    localparam int unsigned A_W     = 6 + SIZE_W + SOURCE_W + ADDR_W + DATA_W / 8 + DATA_W,
    localparam int unsigned D_W     = 5 + SIZE_W + SOURCE_W + 3 + DATA_W,
    localparam int unsigned A_CNT_W = (A_DEPTH == 0) ? 1 : $clog2(A_DEPTH + 1),
    localparam int unsigned D_CNT_W = (D_DEPTH == 0) ? 1 : $clog2(D_DEPTH + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    tl_ul_channel_buffer_if.slave      up_a_if,
    tl_ul_channel_buffer_if.master     dn_a_if,
    tl_ul_channel_buffer_if.slave      dn_d_if,
    tl_ul_channel_buffer_if.master     up_d_if,
    output logic [A_CNT_W-1:0]         a_count_o,
    output logic [D_CNT_W-1:0]         d_count_o
);

    // ---------------------------------------------------------------- A channel
    if (A_DEPTH == 0) begin : g_a_pass
        assign dn_a_if.valid = up_a_if.valid;
        assign dn_a_if.bits  = up_a_if.bits;
        assign up_a_if.ready = dn_a_if.ready;
        assign a_count_o     = '0;
    end else begin : g_a_fifo
        localparam int unsigned PtrW = (A_DEPTH > 1) ? $clog2(A_DEPTH) : 1;

        logic [A_W-1:0]     mem_q [A_DEPTH];
        logic [PtrW-1:0]    wptr_q, rptr_q;
        logic [A_CNT_W-1:0] cnt_q, cnt_d;
        logic               full, enq, deq;

        assign full = (cnt_q == A_CNT_W'(A_DEPTH));
        // Handshakes are forced low during reset so no beat is taken or emitted.
`ifdef TL_BUFFER_PIPE_EN
        assign up_a_if.ready = !rst_i && (!full || dn_a_if.ready);
`else
        assign up_a_if.ready = !rst_i && !full;
`endif
        assign dn_a_if.valid = !rst_i && (cnt_q != '0);
        assign dn_a_if.bits  = mem_q[rptr_q];
        assign enq           = up_a_if.valid && up_a_if.ready;
        assign deq           = dn_a_if.valid && dn_a_if.ready;
        assign a_count_o     = cnt_q;

        always_comb begin
            cnt_d = cnt_q;
            if (enq && !deq) begin
                cnt_d = cnt_q + 1'b1;
            end else if (deq && !enq) begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_q  <= '0;
                wptr_q <= '0;
                rptr_q <= '0;
                for (int i = 0; i < A_DEPTH; i++) begin
                    mem_q[i] <= '0;
                end
            end else begin
                cnt_q <= cnt_d;
                if (enq) begin
                    mem_q[wptr_q] <= up_a_if.bits;
                    wptr_q <= (wptr_q == PtrW'(A_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
                end
                if (deq) begin
                    rptr_q <= (rptr_q == PtrW'(A_DEPTH - 1)) ? '0 : rptr_q + 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------- D channel
    if (D_DEPTH == 0) begin : g_d_pass
        assign up_d_if.valid = dn_d_if.valid;
        assign up_d_if.bits  = dn_d_if.bits;
        assign dn_d_if.ready = up_d_if.ready;
        assign d_count_o     = '0;
    end else begin : g_d_fifo
        localparam int unsigned PtrW = (D_DEPTH > 1) ? $clog2(D_DEPTH) : 1;

        logic [D_W-1:0]     mem_q [D_DEPTH];
        logic [PtrW-1:0]    wptr_q, rptr_q;
        logic [D_CNT_W-1:0] cnt_q, cnt_d;
        logic               full, enq, deq;

        assign full = (cnt_q == D_CNT_W'(D_DEPTH));
`ifdef TL_BUFFER_PIPE_EN
        assign dn_d_if.ready = !rst_i && (!full || up_d_if.ready);
`else
        assign dn_d_if.ready = !rst_i && !full;
`endif
        assign up_d_if.valid = !rst_i && (cnt_q != '0);
        assign up_d_if.bits  = mem_q[rptr_q];
        assign enq           = dn_d_if.valid && dn_d_if.ready;
        assign deq           = up_d_if.valid && up_d_if.ready;
        assign d_count_o     = cnt_q;

        always_comb begin
            cnt_d = cnt_q;
            if (enq && !deq) begin
                cnt_d = cnt_q + 1'b1;
            end else if (deq && !enq) begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_q  <= '0;
                wptr_q <= '0;
                rptr_q <= '0;
                for (int i = 0; i < D_DEPTH; i++) begin
                    mem_q[i] <= '0;
                end
            end else begin
                cnt_q <= cnt_d;
                if (enq) begin
                    mem_q[wptr_q] <= dn_d_if.bits;
                    wptr_q <= (wptr_q == PtrW'(D_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
                end
                if (deq) begin
                    rptr_q <= (rptr_q == PtrW'(D_DEPTH - 1)) ? '0 : rptr_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tl_ul_channel_buffer.sv
// Bench for tl_ul_channel_buffer: two instances (A2/D3 and A0/D1) checked every cycle
// against queue-based channel models; honours TL_BUFFER_PIPE_EN if defined.
module tb_tl_ul_channel_buffer;
    localparam int unsigned AW = 78;
    localparam int unsigned DW = 44;
`ifdef TL_BUFFER_PIPE_EN
    localparam bit Pipe = 1'b1;
`else
    localparam bit Pipe = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tl_ul_channel_buffer_if #(.W(AW)) up_a0 ();
    tl_ul_channel_buffer_if #(.W(AW)) dn_a0 ();
    tl_ul_channel_buffer_if #(.W(DW)) dn_d0 ();
    tl_ul_channel_buffer_if #(.W(DW)) up_d0 ();
    tl_ul_channel_buffer_if #(.W(AW)) up_a1 ();
    tl_ul_channel_buffer_if #(.W(AW)) dn_a1 ();
    tl_ul_channel_buffer_if #(.W(DW)) dn_d1 ();
    tl_ul_channel_buffer_if #(.W(DW)) up_d1 ();

    logic [1:0] a_cnt0, d_cnt0;
    logic [0:0] a_cnt1, d_cnt1;

    tl_ul_channel_buffer #(.A_DEPTH(2), .D_DEPTH(3)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .up_a_if(up_a0), .dn_a_if(dn_a0),
        .dn_d_if(dn_d0), .up_d_if(up_d0), .a_count_o(a_cnt0), .d_count_o(d_cnt0)
    );
    tl_ul_channel_buffer #(.A_DEPTH(0), .D_DEPTH(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .up_a_if(up_a1), .dn_a_if(dn_a1),
        .dn_d_if(dn_d1), .up_d_if(up_d1), .a_count_o(a_cnt1), .d_count_o(d_cnt1)
    );

    // Channels: 0 = dut0 A, 1 = dut0 D, 2 = dut1 A, 3 = dut1 D.
    int          depth [4] = '{2, 3, 0, 1};
    bit          iv    [4];
    bit          ordy  [4];
    int          seq   [4];
    int          delivered [4];
    logic [127:0] mq [4][$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chan(input int ch, input bit r, input logic [127:0] ib, input logic ov,
                        input logic [127:0] ob, input logic ir, input int cnt);
        bit ev, eir;
        if (depth[ch] == 0) begin
            check($sformatf("c%0d_pass_valid", ch), 128'(ov), 128'(iv[ch]));
            check($sformatf("c%0d_pass_ready", ch), 128'(ir), 128'(ordy[ch]));
            check($sformatf("c%0d_pass_bits", ch), ob, ib);
            check($sformatf("c%0d_pass_count", ch), 128'(cnt), 128'd0);
            if (iv[ch] && ordy[ch]) begin
                seq[ch]++;
                delivered[ch]++;
            end
        end else if (r) begin
            check($sformatf("c%0d_rst_valid", ch), 128'(ov), 128'd0);
            check($sformatf("c%0d_rst_ready", ch), 128'(ir), 128'd0);
            mq[ch].delete();
        end else begin
            ev  = mq[ch].size() != 0;
            eir = (mq[ch].size() < depth[ch]) || (Pipe && ordy[ch]);
            check($sformatf("c%0d_valid", ch), 128'(ov), 128'(ev));
            check($sformatf("c%0d_ready", ch), 128'(ir), 128'(eir));
            check($sformatf("c%0d_count", ch), 128'(cnt), 128'(mq[ch].size()));
            if (ev) check($sformatf("c%0d_bits", ch), ob, mq[ch][0]);
            if (ev && ordy[ch]) begin
                void'(mq[ch].pop_front());
                delivered[ch]++;
            end
            if (iv[ch] && eir) begin
                mq[ch].push_back(ib);
                seq[ch]++;
            end
        end
    endtask

    task automatic step(input bit r);
        logic [127:0] ib [4];
        for (int ch = 0; ch < 4; ch++) begin
            ib[ch] = {$urandom, $urandom, $urandom, $urandom};
            if (ch == 0 || ch == 2) begin
                ib[ch][67:36] = 32'h1000 + 32'(4 * seq[ch]);
                ib[ch] = 128'(ib[ch][AW-1:0]);
            end else begin
                ib[ch][32:1] = 32'hA5A5_0000 + 32'(seq[ch]);
                ib[ch] = 128'(ib[ch][DW-1:0]);
            end
        end
        rst = r;
        up_a0.valid = iv[0]; up_a0.bits = ib[0][AW-1:0]; dn_a0.ready = ordy[0];
        dn_d0.valid = iv[1]; dn_d0.bits = ib[1][DW-1:0]; up_d0.ready = ordy[1];
        up_a1.valid = iv[2]; up_a1.bits = ib[2][AW-1:0]; dn_a1.ready = ordy[2];
        dn_d1.valid = iv[3]; dn_d1.bits = ib[3][DW-1:0]; up_d1.ready = ordy[3];
        #1;
        chan(0, r, ib[0], dn_a0.valid, 128'(dn_a0.bits), up_a0.ready, int'(a_cnt0));
        chan(1, r, ib[1], up_d0.valid, 128'(up_d0.bits), dn_d0.ready, int'(d_cnt0));
        chan(2, r, ib[2], dn_a1.valid, 128'(dn_a1.bits), up_a1.ready, int'(a_cnt1));
        chan(3, r, ib[3], up_d1.valid, 128'(up_d1.bits), dn_d1.ready, int'(d_cnt1));
        @(negedge clk);
    endtask

    task automatic set_all(input bit v, input bit rd);
        for (int ch = 0; ch < 4; ch++) begin
            iv[ch]   = v;
            ordy[ch] = rd;
        end
    endtask

    initial begin
        int d0;
        rst = 1'b1;
        set_all(1'b0, 1'b0);
        @(negedge clk);
        step(1'b1);
        step(1'b1);
        step(1'b0);

        // Streaming on the depth-2 A channel: three consecutive beats, slave always ready.
        set_all(1'b0, 1'b1);
        iv[0] = 1'b1;
        d0 = delivered[0];
        repeat (3) step(1'b0);
        iv[0] = 1'b0;
        repeat (3) step(1'b0);
        check("a_stream_delivered", 128'(delivered[0] - d0), 128'd3);

        // Backpressure: three beats into depth 2 with slave stalled, then release.
        iv[0] = 1'b1; ordy[0] = 1'b0;
        repeat (3) step(1'b0);
        iv[0] = 1'b0; ordy[0] = 1'b1;
        repeat (5) step(1'b0);

        // Depth-1 D channel throughput with both sides always ready.
        set_all(1'b0, 1'b1);
        repeat (3) step(1'b0);
        iv[3] = 1'b1;
        d0 = delivered[3];
        repeat (8) step(1'b0);
        check("d1_throughput", 128'(delivered[3] - d0), Pipe ? 128'd7 : 128'd4);
        iv[3] = 1'b0;
        repeat (2) step(1'b0);

        // Random traffic with stalls on every channel.
        for (int i = 0; i < 400; i++) begin
            for (int ch = 0; ch < 4; ch++) begin
                iv[ch]   = ($urandom_range(0, 3) != 0);
                ordy[ch] = ($urandom_range(0, 2) != 0) || (i % 50 < 10 && ch != 1);
                if (i % 100 >= 80) ordy[ch] = $urandom_range(0, 4) == 0;
            end
            step(1'b0);
        end

        // Reset with two beats buffered on A: nothing stale may come out afterwards.
        set_all(1'b0, 1'b1);
        repeat (4) step(1'b0);
        iv[0] = 1'b1; ordy[0] = 1'b0;
        repeat (2) step(1'b0);
        check("pre_rst_count", 128'(a_cnt0), 128'd2);
        step(1'b1);
        set_all(1'b0, 1'b1);
        d0 = delivered[0];
        step(1'b0);
        check("post_rst_a_count", 128'(a_cnt0), 128'd0);
        check("post_rst_a_ready", 128'(up_a0.ready), 128'd1);
        repeat (3) step(1'b0);
        check("post_rst_no_stale", 128'(delivered[0] - d0), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
